// File: rtl/tab_check.sv
// Checker for a multiplication-table stream: verifies result == index*MULT and
// that indices run 0..LAST in order, ignoring repeated (held) samples.
module tab_check #(
  parameter int MULT = 3,
  parameter int LAST = 10,
  parameter int IW   = 4,
  parameter int RW   = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [IW-1:0] index,
  input  logic [RW-1:0] result,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic [3:0]    err_count,
  output logic [IW-1:0] err_index,
  output logic          err_flag
);

  localparam int PW = RW + IW;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state, state_n;
  logic [IW-1:0] exp_q, exp_n, last_q, last_n, eidx_q, eidx_n;
  logic [3:0]    cnt_q, cnt_n;
  logic          flag_q, flag_n;

  // Product at full width so an overflowing product can never alias a result.
  logic [PW-1:0] prod;
  logic          val_ok, seq_ok, start, acc, bad;
  logic [3:0]    base_cnt;
  logic [IW-1:0] base_idx;
  logic          base_flag;

  assign prod   = PW'(index) * PW'(MULT);
  assign val_ok = (prod == PW'(result));
  assign seq_ok = (index == exp_q);
  assign start  = in_valid && (state != RUN) && (index == '0);
  assign acc    = in_valid && (state == RUN) && (index != last_q);
  // A starting index-0 sample is always in sequence; only its value is checked.
  assign bad    = !val_ok || (acc && !seq_ok);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      exp_q  <= '0;
      last_q <= '0;
      cnt_q  <= '0;
      eidx_q <= '0;
      flag_q <= 1'b0;
    end else begin
      state  <= state_n;
      exp_q  <= exp_n;
      last_q <= last_n;
      cnt_q  <= cnt_n;
      eidx_q <= eidx_n;
      flag_q <= flag_n;
    end
  end

  always_comb begin
    state_n   = state;
    exp_n     = exp_q;
    last_n    = last_q;
    cnt_n     = cnt_q;
    eidx_n    = eidx_q;
    flag_n    = flag_q;
    base_cnt  = start ? 4'd0 : cnt_q;
    base_idx  = start ? '0 : eidx_q;
    base_flag = start ? 1'b0 : flag_q;
    if (start || acc) begin
      cnt_n  = base_cnt;
      eidx_n = base_idx;
      flag_n = base_flag;
      if (bad) begin
        if (base_cnt != 4'd15) cnt_n = base_cnt + 4'd1;
        if (!base_flag) begin
          eidx_n = index;
          flag_n = 1'b1;
        end
      end
      // Resync on every accepted sample so a skip costs exactly one error.
      exp_n   = index + IW'(1);
      last_n  = index;
      state_n = (int'(index) >= LAST) ? DONE : RUN;
    end
  end

  always_comb begin
    busy      = (state == RUN);
    done      = (state == DONE);
    pass      = (state == DONE) && (cnt_q == 4'd0);
    err_count = cnt_q;
    err_index = eidx_q;
    err_flag  = flag_q;
  end

endmodule

// File: tb/tb_tab_check.sv
// Bench for tab_check: vector table, directed stream sequences and a random
// stream, all compared against a sample-level reference model.
module tb_tab_check;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic       v0, v1;
  logic [3:0] i0;
  logic [4:0] i1;
  logic [7:0] r0, r1;
  logic       b0, d0, p0, f0, b1, d1, p1, f1;
  logic [3:0] c0, c1, e0;
  logic [4:0] e1;

  tab_check #(.MULT(3), .LAST(10), .IW(4), .RW(8)) u0 (
    .clk(clk), .rst(rst), .in_valid(v0), .index(i0), .result(r0),
    .busy(b0), .done(d0), .pass(p0), .err_count(c0), .err_index(e0), .err_flag(f0));

  tab_check #(.MULT(3), .LAST(20), .IW(5), .RW(8)) u1 (
    .clk(clk), .rst(rst), .in_valid(v1), .index(i1), .result(r1),
    .busy(b1), .done(d1), .pass(p1), .err_count(c1), .err_index(e1), .err_flag(f1));

  int checks = 0;
  int errors = 0;

  // Reference model: mode 0 idle, 1 running, 2 finished.
  int ms[2], mexp[2], mlast[2], mcnt[2], meidx[2];
  bit mflag[2];
  int lastp[2] = '{10, 20};

  typedef struct {
    bit v; int idx; int res;
    bit busy; bit done; bit pass; int cnt; int eidx; bit flag;
  } vec_t;
  vec_t tbl[16];

  task automatic mreset();
    for (int d = 0; d < 2; d++) begin
      ms[d] = 0; mexp[d] = 0; mlast[d] = 0; mcnt[d] = 0; meidx[d] = 0; mflag[d] = 0;
    end
  endtask

  task automatic mstep(input int d, input bit v, input int idx, input int res);
    bit ok;
    if (!v) return;
    if (ms[d] != 1 && idx == 0) begin
      ms[d] = 1; mcnt[d] = 0; meidx[d] = 0; mflag[d] = 0; mexp[d] = 0; mlast[d] = -1;
    end else if (ms[d] != 1 || idx == mlast[d]) begin
      return;
    end
    ok = (idx == mexp[d]) && (idx * 3 == res);
    if (!ok) begin
      if (mcnt[d] < 15) mcnt[d]++;
      if (!mflag[d]) begin mflag[d] = 1; meidx[d] = idx; end
    end
    mexp[d] = idx + 1;
    mlast[d] = idx;
    if (idx >= lastp[d]) ms[d] = 2;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cmp(input int d, input string tag);
    if (d == 0) begin
      check({tag, " busy"}, 32'(b0), 32'(ms[0] == 1));
      check({tag, " done"}, 32'(d0), 32'(ms[0] == 2));
      check({tag, " pass"}, 32'(p0), 32'(ms[0] == 2 && mcnt[0] == 0));
      check({tag, " cnt"},  32'(c0), mcnt[0]);
      check({tag, " eidx"}, 32'(e0), meidx[0]);
      check({tag, " flag"}, 32'(f0), 32'(mflag[0]));
    end else begin
      check({tag, " busy1"}, 32'(b1), 32'(ms[1] == 1));
      check({tag, " done1"}, 32'(d1), 32'(ms[1] == 2));
      check({tag, " pass1"}, 32'(p1), 32'(ms[1] == 2 && mcnt[1] == 0));
      check({tag, " cnt1"},  32'(c1), mcnt[1]);
      check({tag, " eidx1"}, 32'(e1), meidx[1]);
      check({tag, " flag1"}, 32'(f1), 32'(mflag[1]));
    end
  endtask

  // Apply one sample for one cycle, then compare against the model.
  task automatic cyc(input int d, input bit v, input int idx, input int res, input string tag);
    if (d == 0) begin v0 = v; i0 = 4'(idx); r0 = 8'(res); v1 = 1'b0; end
    else        begin v1 = v; i1 = 5'(idx); r1 = 8'(res); v0 = 1'b0; end
    @(posedge clk); #1;
    mstep(d, v, idx, res);
    cmp(d, tag);
  endtask

  task automatic do_reset();
    rst = 1'b0; v0 = 1'b0; v1 = 1'b0;
    mreset();
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  task automatic stream0(input int skip, input int badidx, input int badval,
                         input int hold, input bit bubbles, input string tag);
    for (int i = 0; i <= 10; i++) begin
      if (i == skip) continue;
      for (int h = 0; h < hold; h++) cyc(0, 1, i, (i == badidx) ? badval : 3 * i, tag);
      if (bubbles) cyc(0, 0, i, 0, tag);
    end
  endtask

  task automatic final0(input string tag, input int done_e, input int pass_e,
                        input int cnt_e, input int eidx_e, input int flag_e);
    check({tag, " done"}, 32'(d0), done_e);
    check({tag, " pass"}, 32'(p0), pass_e);
    check({tag, " cnt"},  32'(c0), cnt_e);
    check({tag, " eidx"}, 32'(e0), eidx_e);
    check({tag, " flag"}, 32'(f0), flag_e);
  endtask

  initial begin
    int g;
    //           v idx res  busy done pass cnt eidx flag
    tbl[0]  = '{1,  0,  0,  1, 0, 0, 0,  0, 0};
    tbl[1]  = '{1,  0,  0,  1, 0, 0, 0,  0, 0};
    tbl[2]  = '{0,  5,  0,  1, 0, 0, 0,  0, 0};
    tbl[3]  = '{1,  1,  3,  1, 0, 0, 0,  0, 0};
    tbl[4]  = '{1,  2,  7,  1, 0, 0, 1,  2, 1};
    tbl[5]  = '{1,  4, 12,  1, 0, 0, 2,  2, 1};
    tbl[6]  = '{1,  4, 99,  1, 0, 0, 2,  2, 1};
    tbl[7]  = '{1,  3,  9,  1, 0, 0, 3,  2, 1};
    tbl[8]  = '{1, 10, 30,  0, 1, 0, 4,  2, 1};
    tbl[9]  = '{1, 10, 30,  0, 1, 0, 4,  2, 1};
    tbl[10] = '{1,  5, 15,  0, 1, 0, 4,  2, 1};
    tbl[11] = '{1,  0,  0,  1, 0, 0, 0,  0, 0};
    tbl[12] = '{1,  1,  3,  1, 0, 0, 0,  0, 0};
    tbl[13] = '{1, 12, 36,  0, 1, 0, 1, 12, 1};
    tbl[14] = '{1,  0,  1,  1, 0, 0, 1,  0, 1};
    tbl[15] = '{1,  1,  3,  1, 0, 0, 1,  0, 1};

    v0 = 0; v1 = 0; i0 = 0; i1 = 0; r0 = 0; r1 = 0;
    mreset();
    repeat (2) @(posedge clk);
    #1;
    final0("reset", 0, 0, 0, 0, 0);
    check("reset busy", 32'(b0), 0);
    check("reset busy1", 32'(b1), 0);
    rst = 1'b1;

    for (int k = 0; k < 16; k++) begin
      cyc(0, tbl[k].v, tbl[k].idx, tbl[k].res, $sformatf("tbl%0d", k));
      check($sformatf("tbl%0d busy", k), 32'(b0), 32'(tbl[k].busy));
      final0($sformatf("tbl%0d", k), tbl[k].done, tbl[k].pass, tbl[k].cnt, tbl[k].eidx, tbl[k].flag);
    end

    do_reset();
    stream0(-1, -1, 0, 1, 0, "clean");
    final0("clean", 1, 1, 0, 0, 0);

    stream0(-1, 4, 13, 1, 0, "corrupt");
    final0("corrupt", 1, 0, 1, 4, 1);

    stream0(3, -1, 0, 1, 0, "skip");
    final0("skip", 1, 0, 1, 4, 1);

    stream0(-1, -1, 0, 3, 1, "held");
    final0("held", 1, 1, 0, 0, 0);
    for (int h = 0; h < 4; h++) cyc(0, 1, 10, 30, "hold_after");
    final0("hold_after", 1, 1, 0, 0, 0);

    // Abort mid-run with one prior error, then a clean replay.
    for (int i = 0; i <= 6; i++) cyc(0, 1, i, (i == 2) ? 5 : 3 * i, "pre_abort");
    #2 rst = 1'b0;
    #1;
    mreset();
    final0("abort", 0, 0, 0, 0, 0);
    check("abort busy", 32'(b0), 0);
    @(posedge clk); #1;
    rst = 1'b1;
    stream0(-1, -1, 0, 1, 0, "replay");
    final0("replay", 1, 1, 0, 0, 0);

    cyc(0, 1, 0, 0, "restart");
    check("restart busy", 32'(b0), 1);
    final0("restart", 0, 0, 0, 0, 0);
    for (int i = 1; i <= 10; i++) cyc(0, 1, i, 3 * i, "restart_run");
    for (int i = 0; i <= 10; i++) cyc(0, 1, i, 255, "allbad");
    final0("allbad", 1, 0, 11, 0, 1);

    do_reset();
    g = 0;
    for (int n = 0; n < 800; n++) begin
      int r, idx, res;
      bit v;
      r = $urandom_range(0, 99);
      v = (r >= 10);
      if (ms[0] != 1 && $urandom_range(0, 1) == 1) idx = 0;
      else begin
        r = $urandom_range(0, 99);
        if (r < 70)      idx = g;
        else if (r < 80) idx = (g > 0) ? g - 1 : 0;
        else if (r < 90) idx = $urandom_range(0, 15);
        else             idx = (g + 1) % 16;
      end
      res = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 255) : 3 * idx;
      cyc(0, v, idx, res, "rand");
      if (v && ms[0] == 1 && idx == mlast[0]) g = (idx + 1) % 16;
    end

    for (int i = 0; i <= 20; i++) cyc(1, 1, i, 255, "sat");
    check("sat cnt", 32'(c1), 15);
    check("sat eidx", 32'(e1), 0);
    check("sat done", 32'(d1), 1);
    check("sat pass", 32'(p1), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tab_check.md
Name: tab_check

Overview:
- Consumer/checker for the multiplication-table stream produced by the table-generator blocks: samples (index, result) pairs and verifies result == index*MULT and that indices arrive in order 0..LAST.
- Ignores repeated samples, so it copes with a generator that holds its last output.
- Reports completion, pass/fail, a saturating error count and the first failing index.
- Sits downstream of the generator in self-checking Gate_Verilog benches or on-chip BIST.

Parameters:
- MULT, 3, table multiplier that the checker expects.
- LAST, 10, final index of the table; sequence length is LAST+1.
- IW, 4, index width.
- RW, 8, result width.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous active-low reset; 0 clears all state immediately.
- in_valid  in  1  sample qualifier; tie to 1 for a free-running generator.
- index  in  IW  index from the generator.
- result  in  RW  product from the generator.
- busy  out  1  high in RUN.
- done  out  1  high in DONE.
- pass  out  1  high in DONE when err_count == 0.
- err_count  out  4  number of bad samples, saturates at 15.
- err_index  out  IW  index of the first bad sample; 0 if none.
- err_flag  out  1  sticky; set on the first error of a run.

Behaviour:
- Reset (rst=0, asynchronous):
  - State returns to IDLE.
  - All outputs go to 0: busy, done, pass, err_count, err_index, err_flag.
  - Internal exp=0 and last_idx=0.
- All outputs are registered. Every update appears on the clock edge after the sample.
- A sample is a cycle with in_valid=1. in_valid=0 cycles change nothing.
- Duplicate: in RUN, a sample whose index == last_idx is ignored. This includes the double index-0 the generator emits after reset, and the generator holding its output.
- IDLE:
  - Sample with index==0: start the run.
    - Clear err_count, err_index and err_flag.
    - Check the sample as below.
    - Set exp=1 and last_idx=0, then go to RUN.
  - Any other sample is ignored.
- RUN, non-duplicate sample:
  - Sequence check: index == exp. Value check: result == index*MULT.
  - The product is computed at RW+IW bits, so an overflowing product never matches an RW-bit result.
  - If either check fails:
    - err_count increments, saturating at 15.
    - If err_flag was 0: capture err_index=index and set err_flag.
  - Resync after every accepted sample: exp=index+1 and last_idx=index. A skipped index costs exactly one error.
  - If the accepted index >= LAST: go to DONE and compute pass from the updated err_count.
- DONE:
  - done=1 and busy=0. Outputs hold.
  - A sample with index==0 restarts exactly as from IDLE, including checking that sample; done falls on that edge.
  - Other samples are ignored.
- Simultaneous events: reset has priority over everything.
- Reset mid-run aborts with no done pulse. The next index-0 sample starts a fresh run.
- Boundaries:
  - An index greater than LAST arriving in RUN counts as an error and ends the run.
  - err_count saturated at 15 stays 15.
- Latency: done rises 1 cycle after the first sample with index LAST is accepted.

Test Plan:
- Clean stream: index 0..10 one per cycle, result = 3*index, in_valid=1 -> done rises 1 cycle after index 10; pass=1, err_count=0, err_index=0, err_flag=0.
- Corrupt value: stream 0..10 with result 13 at index 4 -> err_count=1, err_index=4, err_flag=1, done=1, pass=0.
- Skipped index: sequence 0,1,2,4,5..10 with correct products -> exactly 1 error, err_index=4, done after index 10.
- Duplicates and gaps:
  - Each sample held 3 cycles, with in_valid=0 bubbles between samples -> no errors, pass=1.
  - Generator holding 10/30 after done -> outputs unchanged.
- Reset mid-run: pull rst low while at index 6 with one prior error -> all outputs 0 immediately; replay a clean stream -> pass=1.
- Restart and saturation:
  - From DONE, send index 0 -> done falls, busy=1, counters cleared.
  - Then 11 samples with result=0xFF -> err_count=11.
  - With LAST=20 and 21 bad samples -> err_count saturates at 15, err_index=0.
